// File: rtl/draw_pkg.sv
// Shared definitions for the rectangle drawing blocks: sweep states, mode
// encodings, default colour width and a constant-evaluable ceil(log2) helper.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

  localparam int DEF_COL_W = 3;

  // Smallest r with 2**r >= v; sizes counter widths so MAX itself is representable.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rect_sweeper_if.sv
// Request/pixel bundle between a renderer (master) and a rect_sweeper (slave).
import draw_pkg::*;

interface rect_sweeper_if #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int MAX_W = 20,
  parameter int MAX_H = 20,
  parameter int COL_W = DEF_COL_W
);
  localparam int WW = clog2(MAX_W + 1);
  localparam int HW = clog2(MAX_H + 1);

  logic             start;
  logic [X_W-1:0]   x0;
  logic [Y_W-1:0]   y0;
  logic [WW-1:0]    w;
  logic [HW-1:0]    h;
  logic             mode;
  logic [COL_W-1:0] colour_in;
  logic             ready;

  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot;
  logic             busy;
  logic             done;

  modport master (
    output start, x0, y0, w, h, mode, colour_in, ready,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, x0, y0, w, h, mode, colour_in, ready,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/span_counter.sv
// Column/row counter: clears to zero, steps by one, wraps after 'last', and can
// jump straight to 'last' so outline interior rows skip their middle pixels.
module span_counter #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         clr,
  input  logic         en,
  input  logic         jump,
  input  logic [W-1:0] last,
  output logic [W-1:0] value,
  output logic         at_last
);

  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;

  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (en) begin
      if (jump)         value_next = last;
      else if (at_last) value_next = '0;
      else              value_next = value_reg + W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) value_reg <= '0;
    else         value_reg <= value_next;
  end

  assign value   = value_reg;
  assign at_last = (value_reg == last);

endmodule

// File: rtl/rect_sweeper.sv
// Sweeps a runtime-sized rectangle (fill or outline) at a runtime origin, one
// pixel per accepted cycle, with start/busy/done handshake and ready backpressure.
import draw_pkg::*;

module rect_sweeper #(
  parameter int X_W   = 9,
  parameter int Y_W   = 8,
  parameter int MAX_W = 20,
  parameter int MAX_H = 20,
  parameter int COL_W = DEF_COL_W
) (
  input  logic          clock,
  input  logic          resetn,
  rect_sweeper_if.slave bus
);

  localparam int WW = clog2(MAX_W + 1);
  localparam int HW = clog2(MAX_H + 1);
  localparam logic [WW-1:0] W_MAX = WW'(MAX_W);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_H);

  state_t state_reg, state_next;
  logic   plot_reg, plot_next;
  logic   busy_reg, busy_next;
  logic   done_reg, done_next;

  logic [X_W-1:0]   x_reg, x_next, x0_reg;
  logic [Y_W-1:0]   y_reg, y_next, y0_reg;
  logic [WW-1:0]    w_reg, w_clamp, w_m1;
  logic [HW-1:0]    h_reg, h_clamp, h_m1;
  logic             mode_reg;
  logic [COL_W-1:0] colour_reg;

  logic [WW-1:0] cx;
  logic [HW-1:0] cy;
  logic          col_last, row_last;
  logic          launch, empty, accept, jump, final_px;

  assign w_clamp  = (bus.w > W_MAX) ? W_MAX : bus.w;
  assign h_clamp  = (bus.h > H_MAX) ? H_MAX : bus.h;
  assign empty    = (w_clamp == '0) || (h_clamp == '0);
  assign launch   = (state_reg == IDLE) && bus.start;
  assign accept   = plot_reg && bus.ready;
  assign w_m1     = w_reg - WW'(1);
  assign h_m1     = h_reg - HW'(1);
  assign final_px = col_last && row_last;

  // Interior outline rows: after the left edge pixel go straight to the right edge.
  assign jump = (mode_reg == MODE_OUTLINE) && (cy != '0) && !row_last &&
                (cx == '0) && !col_last;

  span_counter #(.W(WW)) u_col (
    .clock   (clock),
    .resetn  (resetn),
    .clr     (launch),
    .en      (accept),
    .jump    (jump),
    .last    (w_m1),
    .value   (cx),
    .at_last (col_last)
  );

  span_counter #(.W(HW)) u_row (
    .clock   (clock),
    .resetn  (resetn),
    .clr     (launch),
    .en      (accept && col_last),
    .jump    (1'b0),
    .last    (h_m1),
    .value   (cy),
    .at_last (row_last)
  );

  always_comb begin
    state_next = state_reg;
    plot_next  = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          busy_next = 1'b1;
          if (empty) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = DRAW;
            plot_next  = 1'b1;
          end
        end
      end
      DRAW: begin
        busy_next = 1'b1;
        if (accept && final_px) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          plot_next = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      plot_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      plot_reg  <= plot_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Screen coordinates track the counters directly so x/y leave a register.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (launch) begin
      x_next = bus.x0;
      y_next = bus.y0;
    end else if (accept) begin
      if (col_last) begin
        x_next = x0_reg;
        y_next = y_reg + Y_W'(1);
      end else if (jump) begin
        x_next = x0_reg + X_W'(w_m1);
      end else begin
        x_next = x_reg + X_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_reg      <= '0;
      y_reg      <= '0;
      x0_reg     <= '0;
      y0_reg     <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      mode_reg   <= MODE_FILL;
      colour_reg <= '0;
    end else begin
      x_reg <= x_next;
      y_reg <= y_next;
      if (launch) begin
        x0_reg     <= bus.x0;
        y0_reg     <= bus.y0;
        w_reg      <= w_clamp;
        h_reg      <= h_clamp;
        mode_reg   <= bus.mode;
        colour_reg <= bus.colour_in;
      end
    end
  end

  assign bus.x      = x_reg;
  assign bus.y      = y_reg;
  assign bus.colour = colour_reg;
  assign bus.plot   = plot_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_rect_sweeper.sv
// Directed, table-driven bench for rect_sweeper: each vector is swept to completion
// and checked for pixel order, counts, timing, hold under backpressure and colour.
module tb_rect_sweeper;

  logic clock;
  logic resetn;

  rect_sweeper_if #(.X_W(9), .Y_W(8), .MAX_W(20), .MAX_H(20), .COL_W(3)) bus ();

  rect_sweeper #(.X_W(9), .Y_W(8), .MAX_W(20), .MAX_H(20), .COL_W(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int   x0;
    int   y0;
    int   w;
    int   h;
    logic mode;
    int   col;
    bit   rdy_toggle;
    int   glitch_k;
    int   exp_n;
    int   exp_busy;
    int   fx;
    int   fy;
    int   lx;
    int   ly;
  } vec_t;

  vec_t vecs [14];
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ex_x[$];
    int ex_y[$];
    int ww, hh, k, n, busy_c, done_c, done_k, last_acc_k;
    int hold_err, seq_err, both_err, quiet_err;
    int fx, fy, lx, ly, fcol;
    logic rdy, prev_stall;
    int px, py;

    ww = (v.w > 20) ? 20 : v.w;
    hh = (v.h > 20) ? 20 : v.h;
    for (int r = 0; r < hh; r++) begin
      for (int c = 0; c < ww; c++) begin
        if (!v.mode || r == 0 || r == hh - 1 || c == 0 || c == ww - 1) begin
          ex_x.push_back((v.x0 + c) % 512);
          ex_y.push_back((v.y0 + r) % 256);
        end
      end
    end

    bus.start     = 1'b1;
    bus.x0        = 9'(v.x0);
    bus.y0        = 8'(v.y0);
    bus.w         = 5'(v.w);
    bus.h         = 5'(v.h);
    bus.mode      = v.mode;
    bus.colour_in = 3'(v.col);
    bus.ready     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;

    k = 0; n = 0; busy_c = 0; done_c = 0; done_k = -1; last_acc_k = -1;
    hold_err = 0; seq_err = 0; both_err = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; fcol = -1;
    prev_stall = 1'b0; px = 0; py = 0;

    while (k < 2000 && done_k < 0) begin
      if (bus.plot && bus.done) both_err++;
      if (prev_stall && (!bus.plot || int'(bus.x) != px || int'(bus.y) != py)) hold_err++;
      if (bus.busy) busy_c++;
      if (bus.done) begin
        done_c++;
        done_k = k;
      end
      rdy = v.rdy_toggle ? (k % 2 == 0) : 1'b1;
      if (k == v.glitch_k) begin
        bus.start = 1'b1;
        bus.x0    = 9'd200;
        bus.w     = 5'd3;
        bus.h     = 5'd3;
      end else begin
        bus.start = 1'b0;
      end
      bus.ready = rdy;
      if (bus.plot) begin
        if (n == 0 && fx < 0) begin
          fx   = int'(bus.x);
          fy   = int'(bus.y);
          fcol = int'(bus.colour);
        end
        if (rdy) begin
          if (n >= ex_x.size() || ex_x[n] != int'(bus.x) || ex_y[n] != int'(bus.y))
            seq_err++;
          n++;
          lx = int'(bus.x);
          ly = int'(bus.y);
          last_acc_k = k;
        end
        prev_stall = !rdy;
        px = int'(bus.x);
        py = int'(bus.y);
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clock); #1;
      k++;
    end
    bus.start = 1'b0;
    bus.ready = 1'b1;

    chk($sformatf("v%0d_done_seen", idx), int'(done_k >= 0), 1);
    chk($sformatf("v%0d_plots", idx), n, v.exp_n);
    chk($sformatf("v%0d_model_plots", idx), n, ex_x.size());
    chk($sformatf("v%0d_sequence", idx), seq_err, 0);
    chk($sformatf("v%0d_busy_cycles", idx), busy_c, v.exp_busy);
    chk($sformatf("v%0d_done_pulses", idx), done_c, 1);
    chk($sformatf("v%0d_plot_with_done", idx), both_err, 0);
    chk($sformatf("v%0d_hold", idx), hold_err, 0);
    if (v.exp_n > 0) begin
      chk($sformatf("v%0d_done_latency", idx), done_k, last_acc_k + 1);
      chk($sformatf("v%0d_first_x", idx), fx, v.fx);
      chk($sformatf("v%0d_first_y", idx), fy, v.fy);
      chk($sformatf("v%0d_last_x", idx), lx, v.lx);
      chk($sformatf("v%0d_last_y", idx), ly, v.ly);
      chk($sformatf("v%0d_colour", idx), fcol, v.col);
    end else begin
      chk($sformatf("v%0d_done_latency", idx), done_k, 0);
    end

    quiet_err = 0;
    repeat (3) begin
      if (bus.plot || bus.busy || bus.done) quiet_err++;
      @(posedge clock); #1;
    end
    chk($sformatf("v%0d_idle_after", idx), quiet_err, 0);

    $display("vec %0d: %0dx%0d at (%0d,%0d) mode=%0d plots=%0d busy=%0d first=(%0d,%0d) last=(%0d,%0d)",
             idx, v.w, v.h, v.x0, v.y0, v.mode, n, busy_c, fx, fy, lx, ly);
  endtask

  initial begin
    int quiet;

    checks   = 0;
    failures = 0;

    //            x0   y0   w   h  mode col tog glitch  n   busy fx   fy   lx   ly
    vecs[0]  = '{100,  50, 20, 20, 1'b0, 5, 1'b0, -1, 400, 401, 100,  50, 119,  69};
    vecs[1]  = '{  0,   0,  4,  3, 1'b1, 2, 1'b0, -1,  10,  11,   0,   0,   3,   2};
    vecs[2]  = '{  7,   9,  2,  2, 1'b0, 7, 1'b1, -1,   4,   8,   7,   9,   8,  10};
    vecs[3]  = '{  5,   5,  0,  5, 1'b0, 1, 1'b0, -1,   0,   1,   0,   0,   0,   0};
    vecs[4]  = '{510,  10,  4,  1, 1'b0, 3, 1'b0, -1,   4,   5, 510,  10,   1,  10};
    vecs[5]  = '{  0,   0, 31,  2, 1'b0, 6, 1'b0, -1,  40,  41,   0,   0,  19,   1};
    vecs[6]  = '{ 20,  30,  5,  5, 1'b1, 4, 1'b0, -1,  16,  17,  20,  30,  24,  34};
    vecs[7]  = '{  3,   3,  1,  4, 1'b1, 1, 1'b0, -1,   4,   5,   3,   3,   3,   6};
    vecs[8]  = '{  0, 100,  6,  1, 1'b1, 2, 1'b0, -1,   6,   7,   0, 100,   5, 100};
    vecs[9]  = '{ 10,  10,  2,  4, 1'b1, 5, 1'b0, -1,   8,   9,  10,  10,  11,  13};
    vecs[10] = '{ 40,  40,  3,  0, 1'b0, 3, 1'b0, -1,   0,   1,   0,   0,   0,   0};
    vecs[11] = '{  0, 255,  3,  2, 1'b0, 6, 1'b0, -1,   6,   7,   0, 255,   2,   0};
    vecs[12] = '{ 30,  40, 10, 10, 1'b0, 7, 1'b0,  5, 100, 101,  30,  40,  39,  49};
    vecs[13] = '{ 50,  60,  3,  1, 1'b0, 4, 1'b0, -1,   3,   4,  50,  60,  52,  60};

    resetn        = 1'b0;
    bus.start     = 1'b0;
    bus.x0        = '0;
    bus.y0        = '0;
    bus.w         = '0;
    bus.h         = '0;
    bus.mode      = 1'b0;
    bus.colour_in = '0;
    bus.ready     = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_x", int'(bus.x), 0);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_colour", int'(bus.colour), 0);
    chk("reset_plot", int'(bus.plot), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
    end

    // Abort a 10x10 fill partway through with a one-cycle reset pulse.
    bus.start     = 1'b1;
    bus.x0        = 9'd0;
    bus.y0        = 8'd0;
    bus.w         = 5'd10;
    bus.h         = 5'd10;
    bus.mode      = 1'b0;
    bus.colour_in = 3'd2;
    bus.ready     = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    chk("pre_reset_plot", int'(bus.plot), 1);
    chk("pre_reset_x", int'(bus.x), 7);
    resetn = 1'b0;
    #1;
    chk("abort_plot", int'(bus.plot), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    quiet = 0;
    repeat (4) begin
      if (bus.plot || bus.busy || bus.done) quiet++;
      @(posedge clock); #1;
    end
    chk("post_reset_quiet", quiet, 0);
    $display("reset pulse mid-sweep: outputs after abort plot=%0d busy=%0d done=%0d",
             bus.plot, bus.busy, bus.done);

    run_vec(vecs[13], 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
